// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a req/ack handshake.
// Requests complete LAT wait cycles after acceptance. Supports LW/LB/LBU/SW/SB.
`default_nettype none

module dmem_responder #(
  parameter int LAT = 2,
  parameter int AW  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
  localparam bit         ZERO_LAT = (LAT == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [2:0]      op_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            ack_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic [31:0]     mem [2**AW];

  logic [2:0]      cur_op;
  logic [AW+1:0]   cur_addr;
  logic [31:0]     cur_wdata;
  logic            complete;
  logic [31:0]     word;
  logic [1:0]      lane;
  logic [7:0]      sel_byte;
  logic            is_store;
  logic            err_d;
  logic [31:0]     rdata_d;
  logic [31:0]     wr_word;
  logic            mem_we;

  logic            unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  // With zero latency the request completes on its acceptance edge, so the
  // live inputs are decoded instead of the latched copy.
  always_comb begin
    cur_op    = op_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_op    = op;
      cur_addr  = addr[AW+1:0];
      cur_wdata = wdata;
    end
  end

  assign complete = ((state_q == IDLE) && req && ZERO_LAT) ||
                    ((state_q == WAIT) && (cnt_q == 4'd0));

  always_comb begin
    word     = mem[cur_addr[AW+1:2]];
    lane     = cur_addr[1:0];
    sel_byte = word[{lane, 3'b000} +: 8];
    is_store = (cur_op == OP_SW) || (cur_op == OP_SB);
    err_d    = 1'b0;
    rdata_d  = 32'd0;
    case (cur_op)
      OP_LW:   rdata_d = word;
      OP_LB:   rdata_d = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  rdata_d = {24'd0, sel_byte};
      OP_SW,
      OP_SB:   rdata_d = 32'd0;
      default: err_d = 1'b1;
    endcase
    if (((cur_op == OP_LW) || (cur_op == OP_SW)) && (lane != 2'd0)) begin
      err_d = 1'b1;
    end
    if (err_d) begin
      rdata_d = 32'd0;
    end
    wr_word = word;
    if (cur_op == OP_SB) begin
      wr_word[{lane, 3'b000} +: 8] = cur_wdata[7:0];
    end else begin
      wr_word = cur_wdata;
    end
  end

  assign mem_we = complete && is_store && !err_d && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_addr[AW+1:2]] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            op_q    <= op;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            if (complete) begin
              state_q <= DONE;
              ack_q   <= 1'b1;
              err_q   <= err_d;
              rdata_q <= rdata_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (complete) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
            err_q   <= err_d;
            rdata_q <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LAT=2 instance and a LAT=0 instance.
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req2, req0;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy2, ack2, err2;
  logic [31:0] rdata2;
  logic        busy0, ack0, err0;
  logic [31:0] rdata0;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] LW = 3'b000, LB = 3'b001, LBU = 3'b010, SW = 3'b100, SB = 3'b101;

  always #5 clk = ~clk;

  dmem_responder #(.LAT(2), .AW(10)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy2), .ack(ack2), .rdata(rdata2), .err(err2)
  );

  dmem_responder #(.LAT(0), .AW(10)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One transaction on the LAT=2 instance; lat counts edges after acceptance until ack.
  task automatic xact(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    op = o; addr = a; wdata = d; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    lat = 0;
    while (!ack2 && lat < 20) begin
      check("busy_wait", {31'd0, busy2}, 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata2;
    er = err2;
    check("busy_done", {31'd0, busy2}, 32'd1);
    @(posedge clk); #1;
    check("ack_pulse", {30'd0, ack2, busy2}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst = 1'b1; req2 = 1'b0; req0 = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out2", {busy2, ack2, err2, 29'd0} | rdata2, 32'd0);
    check("rst_out0", {busy0, ack0, err0, 29'd0} | rdata0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_hold", {busy2, ack2, err2, 29'd0} | rdata2, 32'd0);
    end

    xact(SW, 32'h010, 32'h12345678, rd, er, lat);
    check("sw_lat", lat, 32'd2);
    check("sw_err", {31'd0, er}, 32'd0);
    xact(LW, 32'h010, 32'h0, rd, er, lat);
    check("lw_lat", lat, 32'd2);
    check("lw_data", rd, 32'h12345678);

    xact(SW, 32'h004, 32'h00000000, rd, er, lat);
    xact(SB, 32'h005, 32'h123456AB, rd, er, lat);
    check("sb_err", {31'd0, er}, 32'd0);
    xact(LB, 32'h005, 32'h0, rd, er, lat);
    check("lb_sext", rd, 32'hFFFFFFAB);
    xact(LBU, 32'h005, 32'h0, rd, er, lat);
    check("lbu_zext", rd, 32'h000000AB);
    xact(LW, 32'h004, 32'h0, rd, er, lat);
    check("sb_merge", rd, 32'h0000AB00);
    xact(LB, 32'h013, 32'h0, rd, er, lat);
    check("lb_lane3", rd, 32'h00000012);

    xact(LW, 32'h006, 32'h0, rd, er, lat);
    check("lw_mis_err", {31'd0, er}, 32'd1);
    check("lw_mis_data", rd, 32'd0);
    xact(SW, 32'h008, 32'hCAFEF00D, rd, er, lat);
    xact(3'b111, 32'h008, 32'h0, rd, er, lat);
    check("badop_err", {31'd0, er}, 32'd1);
    check("badop_data", rd, 32'd0);
    xact(SW, 32'h00A, 32'h11111111, rd, er, lat);
    check("sw_mis_err", {31'd0, er}, 32'd1);
    xact(LW, 32'h008, 32'h0, rd, er, lat);
    check("no_write", rd, 32'hCAFEF00D);
    check("no_write_err", {31'd0, er}, 32'd0);

    // Store aborted by reset during its first wait cycle.
    xact(SW, 32'h020, 32'h55AA55AA, rd, er, lat);
    @(negedge clk);
    op = SW; addr = 32'h020; wdata = 32'hDEADBEEF; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    check("abort_busy", {31'd0, busy2}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_rst", {busy2, ack2, err2, 29'd0}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_noack", {31'd0, ack2}, 32'd0);
    end
    xact(LW, 32'h020, 32'h0, rd, er, lat);
    check("abort_keep", rd, 32'h55AA55AA);

    // Zero-latency instance.
    @(negedge clk);
    op = SW; addr = 32'h040; wdata = 32'h0BADCAFE; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    check("l0_sw_ack", {30'd0, ack0, err0}, 32'd2);
    @(posedge clk); #1;
    check("l0_sw_drop", {30'd0, ack0, busy0}, 32'd0);
    @(negedge clk);
    op = LW; addr = 32'h040; req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("l0_ack", {31'd0, ack0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("l0_data", rdata0, (i % 2 == 0) ? 32'h0BADCAFE : 32'd0);
    end
    req0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
